// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - execute-stage ALU with iterative shift-add multiplier and pipeline stall
module exec_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             valid_o,
    output logic             stall_o,
    output logic             illegal_o
);
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_MUL = 4'd5;

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, MUL_RUN} state_t;
    state_t state, state_next;

    logic [WIDTH-1:0] acc, mcand, mplier, acc_next, alu_res;
    logic [CW-1:0]    cnt;
    logic             alu_legal, slt_bit, last_iter;

    always_comb begin
        alu_res   = '0;
        alu_legal = 1'b1;
        slt_bit   = ($signed(src_a_i) < $signed(src_b_i));
        case (op_i)
            ALU_ADD: alu_res = src_a_i + src_b_i;
            ALU_SUB: alu_res = src_a_i - src_b_i;
            ALU_AND: alu_res = src_a_i & src_b_i;
            ALU_OR:  alu_res = src_a_i | src_b_i;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            ALU_MUL: alu_res = '0;
            default: alu_legal = 1'b0;
        endcase
    end

    assign acc_next  = mplier[0] ? acc + mcand : acc;
    assign last_iter = (cnt == LAST);
    // Releasing the stall during the final iteration lets upstream advance on the result edge.
    assign stall_o   = !flush_i && ((state == IDLE && valid_i && op_i == ALU_MUL) ||
                                    (state == MUL_RUN && !last_iter));

    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (valid_i && op_i == ALU_MUL) state_next = MUL_RUN;
                MUL_RUN: if (last_iter) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            result_o  <= '0;
            zero_o    <= 1'b0;
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
        end else if (flush_i) begin
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
        end else if (state == IDLE) begin
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
            if (valid_i) begin
                if (op_i == ALU_MUL) begin
                    acc    <= '0;
                    mcand  <= src_a_i;
                    mplier <= src_b_i;
                    cnt    <= '0;
                end else if (alu_legal) begin
                    result_o <= alu_res;
                    zero_o   <= (alu_res == '0);
                    valid_o  <= 1'b1;
                end else begin
                    result_o  <= '0;
                    zero_o    <= 1'b1;
                    valid_o   <= 1'b1;
                    illegal_o <= 1'b1;
                end
            end
        end else begin
            acc       <= acc_next;
            mcand     <= mcand << 1;
            mplier    <= mplier >> 1;
            cnt       <= cnt + CW'(1);
            illegal_o <= 1'b0;
            valid_o   <= last_iter;
            if (last_iter) begin
                result_o <= acc_next;
                zero_o   <= (acc_next == '0);
            end
        end
    end
endmodule

// File: tb/tb_exec_alu.sv
// tb/tb_exec_alu.sv - table-driven and scoreboard bench for exec_alu
module tb_exec_alu;
    localparam int W = 32;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
                           OP_OR  = 4'd3, OP_SLT = 4'd4, OP_MUL = 4'd5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_i = 1'b0;
    logic [3:0]    op_i = 4'd0;
    logic [W-1:0]  src_a_i = '0, src_b_i = '0;
    logic          flush_i = 1'b0;
    logic [W-1:0]  result_o;
    logic          zero_o, valid_o, stall_o, illegal_o;

    exec_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .op_i(op_i),
        .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i),
        .result_o(result_o), .zero_o(zero_o), .valid_o(valid_o),
        .stall_o(stall_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b, res;
        logic         zero;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         zero, ill;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] res, input logic ill);
        exp_t e;
        e.res  = res;
        e.zero = (res == '0);
        e.ill  = ill;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (valid_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'(valid_o), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_result", result_o, e.res);
                chk("sb_zero", 32'(zero_o), 32'(e.zero));
                chk("sb_illegal", 32'(illegal_o), 32'(e.ill));
            end
        end else if (illegal_o) begin
            chk("illegal_without_valid", 32'(illegal_o), 32'd0);
        end
    end

    // Holds the MUL on the inputs through the stall; returns at the start of cycle N+WIDTH+1.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp);
        valid_i = 1'b1; op_i = OP_MUL; src_a_i = a; src_b_i = b;
        push(exp, 1'b0);
        for (int k = 0; k <= W; k++) begin
            @(negedge clk);
            chk("mul_stall", 32'(stall_o), 32'(k < W));
            chk("mul_no_early_valid", 32'(valid_o), 32'd0);
            tick();
        end
        valid_i = 1'b0;
    endtask

    task automatic start_mul_run10(input logic [W-1:0] a, input logic [W-1:0] b);
        valid_i = 1'b1; op_i = OP_MUL; src_a_i = a; src_b_i = b;
        for (int k = 0; k < 10; k++) tick();
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{OP_ADD, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1};
        vt[1] = '{OP_SUB, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0};
        vt[2] = '{OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
        vt[3] = '{OP_OR,  32'h0F,        32'hF0,        32'hFF,        1'b0};
        vt[4] = '{OP_SLT, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0};
        vt[5] = '{OP_SLT, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1};

        valid_i = 1'b1; op_i = OP_ADD; src_a_i = 32'd3; src_b_i = 32'd4;
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk);
        chk("rst_result", result_o, 32'd0);
        chk("rst_zero", 32'(zero_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_illegal", 32'(illegal_o), 32'd0);
        chk("rst_stall_add", 32'(stall_o), 32'd0);
        op_i = OP_MUL;
        #1 chk("rst_stall_mul", 32'(stall_o), 32'd1);
        valid_i = 1'b0; op_i = OP_ADD;
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            valid_i = 1'b1; op_i = vt[i].op; src_a_i = vt[i].a; src_b_i = vt[i].b;
            push(vt[i].res, 1'b0);
            @(negedge clk);
            chk("b2b_stall", 32'(stall_o), 32'd0);
            if (i > 0) chk("b2b_valid", 32'(valid_o), 32'd1);
            tick();
        end
        valid_i = 1'b0;
        @(negedge clk);
        chk("b2b_valid_last", 32'(valid_o), 32'd1);
        chk("b2b_zero_last", 32'(zero_o), 32'(vt[5].zero));
        tick();
        @(negedge clk);
        chk("b2b_valid_clear", 32'(valid_o), 32'd0);
        tick();

        run_mul(32'h0001_0003, 32'h0000_0005, 32'h0005_000F);
        valid_i = 1'b1; op_i = OP_ADD; src_a_i = 32'd2; src_b_i = 32'd2;
        push(32'd4, 1'b0);
        @(negedge clk);
        chk("mul_valid", 32'(valid_o), 32'd1);
        chk("mul_result", result_o, 32'h0005_000F);
        chk("post_mul_stall", 32'(stall_o), 32'd0);
        tick();
        valid_i = 1'b0;
        @(negedge clk);
        chk("post_mul_add", result_o, 32'd4);
        chk("post_mul_add_valid", 32'(valid_o), 32'd1);
        tick();

        run_mul(32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);
        tick();
        run_mul(32'h8000_0000, 32'd2, 32'h0);
        @(negedge clk);
        chk("mul_ovf_zero", 32'(zero_o), 32'd1);
        tick();

        start_mul_run10(32'd9, 32'd9);
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_stall", 32'(stall_o), 32'd0);
        tick();
        flush_i = 1'b0;
        op_i = OP_ADD; src_a_i = 32'd10; src_b_i = 32'd20;
        push(32'd30, 1'b0);
        @(negedge clk);
        chk("flush_no_valid", 32'(valid_o), 32'd0);
        chk("flush_stall_after", 32'(stall_o), 32'd0);
        tick();
        valid_i = 1'b0;
        @(negedge clk);
        chk("flush_next_add", result_o, 32'd30);
        chk("flush_next_valid", 32'(valid_o), 32'd1);
        tick();

        start_mul_run10(32'd9, 32'd9);
        rst_n = 1'b0; op_i = OP_ADD;
        tick();
        @(negedge clk);
        chk("mrst_result", result_o, 32'd0);
        chk("mrst_zero", 32'(zero_o), 32'd0);
        chk("mrst_valid", 32'(valid_o), 32'd0);
        chk("mrst_stall", 32'(stall_o), 32'd0);
        rst_n = 1'b1; valid_i = 1'b0;
        tick();
        @(negedge clk);
        chk("mrst_no_result", 32'(valid_o), 32'd0);
        tick();

        valid_i = 1'b1; op_i = 4'hF; src_a_i = 32'h1234; src_b_i = 32'h5678;
        push(32'd0, 1'b1);
        @(negedge clk);
        chk("illegal_stall", 32'(stall_o), 32'd0);
        tick();
        valid_i = 1'b0;
        @(negedge clk);
        chk("illegal_valid", 32'(valid_o), 32'd1);
        chk("illegal_flag", 32'(illegal_o), 32'd1);
        chk("illegal_result", result_o, 32'd0);
        tick();
        @(negedge clk);
        chk("illegal_clear", 32'(illegal_o), 32'd0);
        tick();
        tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
